// File: rtl/uart_rx_core_if.sv
// Receive-side bus of the 8N1 UART receiver: serial line in, buffered byte and status out.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 rd;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 done;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx, rd,
    input  data_out, valid, done, busy, frame_err, overrun
  );

  modport slave (
    input  rx, rd,
    output data_out, valid, done, busy, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronised rx, majority vote at mid-bit, stop check,
// one-entry byte buffer with valid/rd handshake and sticky overrun.
//
// state | meaning
// IDLE  | line idle, waiting for a 1->0 edge on rx_s
// START | half a bit into the start bit, confirm it is still low
// DATA  | sample DATA_BITS data bits, LSB first
// STOP  | sample the stop bit, publish or flag the frame
// BREAK | stop bit was low, wait for the line to return high
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 40,
  parameter int DATA_BITS    = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_core_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync_1, rx_s;
  logic [1:0]           hist;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 vote, fall, tc, last_bit, rd_hit;
  logic                 cnt_load, idx_clr, shift_en, frame_ok, frame_bad;
  logic [CW-1:0]        cnt_load_val;

  // Vote window is rx_s now plus the two previous cycles.
  assign vote     = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
  assign fall     = hist[0] & ~rx_s;
  assign tc       = (cnt == '0);
  assign last_bit = (bit_idx == LAST_IDX);
  assign rd_hit   = bus.rd & bus.valid;
  assign bus.busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
      hist   <= 2'b11;
    end else begin
      sync_1 <= bus.rx;
      rx_s   <= sync_1;
      hist   <= {hist[0], rx_s};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fall) state_d = ST_START;
      ST_START: if (tc) state_d = vote ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tc && last_bit) state_d = ST_STOP;
      ST_STOP:  if (tc) state_d = vote ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = FULL_TC;
    idx_clr      = 1'b0;
    shift_en     = 1'b0;
    frame_ok     = 1'b0;
    frame_bad    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          cnt_load     = 1'b1;
          cnt_load_val = HALF_TC;
        end
      end
      ST_START: begin
        if (tc && !vote) begin
          cnt_load = 1'b1;
          idx_clr  = 1'b1;
        end
      end
      ST_DATA: begin
        if (tc) begin
          shift_en = 1'b1;
          cnt_load = 1'b1;
        end
      end
      ST_STOP: begin
        if (tc) begin
          frame_ok  = vote;
          frame_bad = ~vote;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      bus.data_out  <= '0;
      bus.valid     <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.done      <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      if (cnt_load)  cnt <= cnt_load_val;
      else if (!tc)  cnt <= cnt - CW'(1);

      if (idx_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + BW'(1);

      if (shift_en) shift_q <= {vote, shift_q[DATA_BITS-1:1]};

      bus.done      <= frame_ok;
      bus.frame_err <= frame_bad;

      // A read landing on the same edge as a new byte wins over overrun.
      if (frame_ok) begin
        bus.data_out <= shift_q;
        bus.valid    <= 1'b1;
        if (rd_hit)         bus.overrun <= 1'b0;
        else if (bus.valid) bus.overrun <= 1'b1;
      end else if (rd_hit) begin
        bus.valid   <= 1'b0;
        bus.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: bytes queued as frames are driven, popped on done.
module tb_uart_rx_core;

  localparam int CPB = 40;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  int   ferr_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_core_if #(.DATA_BITS(8)) bus ();

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // rd_mode: 0 no read, 1 rd on the edge that publishes the byte, 2 rd just after done
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_mode);
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(CPB);
    end
    bus.rx = stop_bit;
    if (rd_mode == 1) begin
      tick(22);
      bus.rd = 1'b1;
      tick(1);
      bus.rd = 1'b0;
      tick(17);
    end else if (rd_mode == 2) begin
      tick(24);
      bus.rd = 1'b1;
      tick(1);
      bus.rd = 1'b0;
      tick(15);
    end else begin
      tick(CPB);
    end
  endtask

  task automatic read_byte();
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        done_cnt++;
        chk("done_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("rx_byte", bus.data_out, exp_q.pop_front());
      end
      if (bus.frame_err) ferr_cnt++;
    end
  end

  initial begin
    int busy_n;
    reset  = 1'b1;
    bus.rx = 1'b1;
    bus.rd = 1'b0;
    tick(5);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_flags", {bus.valid, bus.done, bus.busy, bus.frame_err, bus.overrun}, 0);
    reset = 1'b0;
    tick(5);

    // good frame
    exp_q.push_back(8'h18);
    send_frame(8'h18, 1'b1, 0);
    tick(3);
    chk("good_done_cnt", done_cnt, 1);
    chk("good_valid", bus.valid, 1);
    chk("good_data", bus.data_out, 8'h18);
    chk("good_ferr", ferr_cnt, 0);
    read_byte();
    chk("good_rd_valid", bus.valid, 0);

    // glitch on the line
    busy_n = 0;
    bus.rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) bus.rx = 1'b1;
      if (bus.busy) busy_n++;
      tick(1);
    end
    chk("glitch_busy_cycles", busy_n, 20);
    chk("glitch_busy_end", bus.busy, 0);
    chk("glitch_done_cnt", done_cnt, 1);
    chk("glitch_ferr", ferr_cnt, 0);
    exp_q.push_back(8'h45);
    send_frame(8'h45, 1'b1, 0);
    tick(3);
    chk("after_glitch_data", bus.data_out, 8'h45);

    // framing error, 0x45 left unread
    send_frame(8'h55, 1'b0, 0);
    tick(60);
    chk("ferr_busy_low_line", bus.busy, 1);
    chk("ferr_cnt", ferr_cnt, 1);
    chk("ferr_valid_kept", bus.valid, 1);
    chk("ferr_data_kept", bus.data_out, 8'h45);
    bus.rx = 1'b1;
    tick(5);
    chk("ferr_busy_release", bus.busy, 0);
    read_byte();
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 0);
    tick(3);
    chk("after_ferr_data", bus.data_out, 8'h0F);
    chk("after_ferr_valid", bus.valid, 1);
    read_byte();

    // overrun without read
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1, 0);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 0);
    tick(2);
    chk("ovr_data", bus.data_out, 8'hFF);
    chk("ovr_valid", bus.valid, 1);
    chk("ovr_flag", bus.overrun, 1);
    read_byte();
    chk("ovr_rd_valid", bus.valid, 0);
    chk("ovr_rd_flag", bus.overrun, 0);

    // read coincides with the second byte landing
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1, 0);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 1);
    tick(2);
    chk("ovr_rd_same_flag", bus.overrun, 0);
    chk("ovr_rd_same_valid", bus.valid, 1);
    chk("ovr_rd_same_data", bus.data_out, 8'hFF);
    read_byte();

    // back-to-back frames, no idle gap
    busy_n = done_cnt;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 2);
    exp_q.push_back(8'h80);
    send_frame(8'h80, 1'b1, 2);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 2);
    tick(3);
    chk("b2b_done_cnt", done_cnt - busy_n, 3);
    chk("b2b_overrun", bus.overrun, 0);
    chk("b2b_valid", bus.valid, 0);
    chk("b2b_ferr", ferr_cnt, 1);
    chk("b2b_data", bus.data_out, 8'hF0);

    // reset in the middle of 0x96, held past its stop bit
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 8'(8'h96 >> i) & 1'b1;
      tick(CPB);
    end
    bus.rx = 1'b1;
    tick(20);
    reset = 1'b1;
    tick(20);
    for (int i = 5; i < 8; i++) begin
      bus.rx = 8'(8'h96 >> i) & 1'b1;
      tick(CPB);
    end
    bus.rx = 1'b1;
    tick(CPB + 10);
    chk("midrst_data_out", bus.data_out, 0);
    chk("midrst_flags", {bus.valid, bus.done, bus.busy, bus.frame_err, bus.overrun}, 0);
    reset = 1'b0;
    tick(5);
    busy_n = ferr_cnt;
    exp_q.push_back(8'h48);
    send_frame(8'h48, 1'b1, 0);
    tick(3);
    chk("post_rst_data", bus.data_out, 8'h48);
    chk("post_rst_valid", bus.valid, 1);
    chk("post_rst_ferr", ferr_cnt - busy_n, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Standalone UART receiver: the receive end of the team's 8N1 serial link, paired with the transmitter inside `UART_Protocol`. It synchronises the asynchronous `rx` line, validates the start bit and majority-votes every bit at mid-period. It checks the stop bit and holds each received byte in a one-entry buffer with a valid/read handshake and an overrun flag. Default timing is 9600 baud from the 384 kHz system clock, i.e. 40 clocks per bit.

## Interface
- `CLKS_PER_BIT`, 40, clocks per bit period; must be even and ≥ 8.
- `DATA_BITS`, 8, data bits per frame; LSB first, no parity, one stop bit.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line; idles high; asynchronous to `clk`.
- `rd`  in  1  read strobe; consumes the buffered byte.
- `data_out`  out  DATA_BITS  last good byte; reset value 0.
- `valid`  out  1  `data_out` holds an unread byte; reset value 0.
- `done`  out  1  one-cycle pulse per good frame; reset value 0.
- `busy`  out  1  frame reception in progress; reset value 0.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0; reset value 0.
- `overrun`  out  1  sticky: a byte was overwritten before it was read; reset value 0.

## Operation
- **Synchroniser.** `rx` passes through a 2-flop synchroniser; both flops reset to 1. The output is `rx_s`.
- **Vote.** A 3-bit history of `rx_s` is kept, reset to 3'b111. The vote is the majority of the three bits.
- **Start detection.** Starts are detected on a falling edge only: previous `rx_s`=1 and current `rx_s`=0. A line held low does not retrigger.
- **State machine.** States are IDLE, START, DATA, STOP and BREAK. `busy` = (state ≠ IDLE).
  - IDLE: a falling edge moves to START and clears the counter.
  - START: counter runs 0..CLKS_PER_BIT/2−1. At the last count, vote=0 moves to DATA with counter=0 and bit index=0. Vote=1 is a glitch: return to IDLE with no flags.
  - DATA: counter runs 0..CLKS_PER_BIT−1. At the last count the vote is shifted in LSB-first and the bit index increments. After bit DATA_BITS−1, move to STOP.
  - STOP: at counter CLKS_PER_BIT−1, check the vote.
    - Vote=1: `data_out` ← shift register, `done`=1 for one cycle, `valid`=1, go to IDLE.
    - Vote=0: `frame_err`=1 for one cycle, byte discarded, `data_out`/`valid` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE.
- **Handshake.**
  - `rd` with `valid`=1 clears `valid` and `overrun` on the next edge.
  - `rd` with `valid`=0 has no effect.
  - `done` while `valid`=1 and no `rd` in the same cycle sets `overrun`. The new byte replaces the old one.
  - `done` and `rd` in the same cycle: the new byte is loaded, `valid` stays 1, and `overrun` is cleared, not set.
- **Reset mid-frame.** Every register returns to its reset value and the FSM goes to IDLE; the partial frame is dropped. Reception resumes at the next 1→0 edge of `rx_s`.

## Timing
- Synchroniser latency is 2 clocks from the `rx` pin to `rx_s`.
- Let E be the first cycle with `rx_s`=0 after a 1.
  - Start vote: cycle E+CLKS_PER_BIT/2.
  - Data bit i vote: cycle E+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - Stop vote: cycle E+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT. With defaults this is E+380.
  - `done`, `valid` and `data_out` are visible at E+381.
- The FSM is back in IDLE half a bit before the end of the stop bit. A start bit with no idle gap is therefore caught.
- Each vote covers `rx_s` at the vote cycle and the two cycles before it.
- Outputs are registered; no combinational path from `rx` or `rd` to any output.

## Test plan
- **Good frame.** Apply reset, then send frame 0x18 at 40 clocks/bit. Expect `done` pulses once, `data_out`=0x18, `valid`=1, `frame_err`=0. Pulse `rd`; `valid`=0 next cycle.
- **Glitch.** Drive `rx` low for 10 clocks. Expect `busy` to rise and then drop after 20 clocks, with no `done` or `frame_err`. Then send 0x45; expect `data_out`=0x45.
- **Framing error.** Send 0x55 with stop bit 0 and hold `rx` low 100 clocks. Expect a one-cycle `frame_err` pulse, `valid` and `data_out` unchanged, and `busy`=1 until `rx` returns high. A following 0x0F frame is received correctly.
- **Overrun.**
  - Send 0xAA then 0xFF with no `rd`. Expect `data_out`=0xFF, `valid`=1, `overrun`=1. `rd` clears both flags.
  - Repeat with `rd` asserted in the `done` cycle of 0xFF. Expect `overrun`=0 and `valid`=1.
- **Back-to-back frames.** Send 0x01, 0x80, 0xF0 with zero idle gap, pulsing `rd` after each `done`. Expect three `done` pulses, the bytes in order, and no flags.
- **Reset mid-frame.** Assert `reset` during bit 4 of 0x96 and hold it past that frame's stop bit. All outputs read 0 and `busy`=0 while reset is held. After release, send 0x48; expect `data_out`=0x48 and no `frame_err`.
